// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared states, widths and operand helper for the divider.
package div_unit_pkg;
  localparam int REG_W = 32;
  localparam int DREG_W = 64;
  localparam logic [5:0] LAST_ITER = 6'd31;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  function automatic logic [REG_W-1:0] abs_op(input logic [REG_W-1:0] v, input logic sgn);
    return (sgn && v[REG_W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one restoring-division iteration on the 65-bit working register.
// Ports: wr (current working register), divisor (|op2|), wr_nxt (after one iteration).
module div_unit_step (
  input  logic [64:0] wr,
  input  logic [31:0] divisor,
  output logic [64:0] wr_nxt
);
  logic [64:0] sh;
  logic [32:0] trial;
  assign sh = {wr[63:0], 1'b0};
  // the shifted partial remainder can reach 33 bits when the divisor exceeds 2^31
  assign trial = sh[64:32] - {1'b0, divisor};
  assign wr_nxt = trial[32] ? sh : {trial, sh[31:1], 1'b1};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit signed/unsigned divider with start/ready handshake.
// Ports: clk, rst (sync, active-low), signed_div_i, opdata1_i (dividend),
//   opdata2_i (divisor), start_i, annul_i, result_o {remainder, quotient}, ready_o.
// Option: DIV_ZERO_DETECT_EN makes a zero divisor report {0,0} after one cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [REG_W-1:0]  opdata1_i,
  input  logic [REG_W-1:0]  opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [DREG_W-1:0] result_o,
  output logic              ready_o
);
  div_state_e state;
  logic [64:0] wr, wr_nxt;
  logic [REG_W-1:0] dvs, quo, rem;
  logic [5:0] cnt;
  logic sign_q, sign_r;
  div_unit_step u_step (.wr(wr), .divisor(dvs), .wr_nxt(wr_nxt));
  assign quo = wr_nxt[31:0];
  assign rem = wr_nxt[63:32];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= DIV_FREE;
      result_o <= '0;
      ready_o <= 1'b0;
      cnt <= '0;
      wr <= '0;
      dvs <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            sign_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            sign_r <= signed_div_i & opdata1_i[31];
            dvs <= abs_op(opdata2_i, signed_div_i);
            wr <= {33'b0, abs_op(opdata1_i, signed_div_i)};
            cnt <= '0;
`ifdef DIV_ZERO_DETECT_EN
            state <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
`else
            state <= DIV_ON;
`endif
          end
        end
        DIV_BY_ZERO: begin
          result_o <= '0;
          ready_o <= !annul_i;
          state <= annul_i ? DIV_FREE : DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
            result_o <= '0;
            ready_o <= 1'b0;
          end else begin
            wr <= wr_nxt;
            cnt <= cnt + 6'd1;
            if (cnt == LAST_ITER) begin
              result_o <= {sign_r ? -rem : rem, sign_q ? -quo : quo};
              ready_o <= 1'b1;
              state <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (!start_i) begin
            state <= DIV_FREE;
            result_o <= '0;
            ready_o <= 1'b0;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end
endmodule
